// File: rtl/irq_sched_pkg.sv
// Shared types for the interrupt scheduler: FSM state encoding and core-index sizing.
// Pure declarations; no logic, no timing.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_CLEAR    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    // Index width for n cores; a single core still needs one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// Core-request / host-service bundle of the interrupt scheduler.
// master = scheduler side, slave = cores plus host side.
interface irq_scheduler_if #(
    parameter int N_CORES    = 4,
    parameter int ID_W       = 2,
    parameter int STAT_WIDTH = 16
);
    logic [N_CORES-1:0]    int_req_n;
    logic                  host_ack;
    logic [STAT_WIDTH-1:0] host_clear;
    logic [STAT_WIDTH-1:0] host_mask;
    logic                  host_irq;
    logic [ID_W-1:0]       host_id;
    logic [N_CORES-1:0]    en_clear;
    logic [STAT_WIDTH-1:0] clear;
    logic [STAT_WIDTH-1:0] mask;
    logic                  timeout;
    logic                  busy;

    modport master (
        input  int_req_n, host_ack, host_clear, host_mask,
        output host_irq, host_id, en_clear, clear, mask, timeout, busy
    );

    modport slave (
        output int_req_n, host_ack, host_clear, host_mask,
        input  host_irq, host_id, en_clear, clear, mask, timeout, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending core above last_id, wrapping to core 0.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int ID_W    = 2
) (
    input  logic [N_CORES-1:0] pending,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    next_id
);

    logic            w_hi_found;
    logic [ID_W-1:0] w_hi_id;
    logic            w_lo_found;
    logic [ID_W-1:0] w_lo_id;

    // Descending scan: the last hit is the lowest index, both overall and above last_id.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_found = 1'b0;
        w_lo_id    = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                w_lo_found = 1'b1;
                w_lo_id    = ID_W'(i);
                if (i > int'(last_id)) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = ID_W'(i);
                end
            end
        end
    end

    assign found   = w_lo_found;
    assign next_id = w_hi_found ? w_hi_id : w_lo_id;

endmodule

// File: rtl/irq_scheduler.sv
// Round-robin interrupt scheduler: grant 1 cycle after request, clear strobe 1 cycle after ack,
// HOLDOFF_CYC-cycle holdoff; a silent host is abandoned after TMO_CYCLES.
module irq_scheduler
    import irq_sched_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int ID_W        = id_width(N_CORES),
    parameter int STAT_WIDTH  = 16,
    parameter int TMO_CYCLES  = 1024,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_a,
    irq_scheduler_if.master bus
);

    localparam int TMO_W = $clog2(TMO_CYCLES);
    localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYC - 1);

    state_t                r_state;
    logic [ID_W-1:0]       r_last_id;
    logic [ID_W-1:0]       r_host_id;
    logic                  r_host_irq;
    logic [N_CORES-1:0]    r_en_clear;
    logic [STAT_WIDTH-1:0] r_clear;
    logic [STAT_WIDTH-1:0] r_mask;
    logic                  r_timeout;
    logic                  r_busy;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [HO_W-1:0]       r_ho_cnt;

    logic                  w_found;
    logic [ID_W-1:0]       w_next_id;
    logic [N_CORES-1:0]    w_grant_oh;

    rr_arbiter #(
        .N_CORES (N_CORES),
        .ID_W    (ID_W)
    ) u_arb (
        .pending (~bus.int_req_n),
        .last_id (r_last_id),
        .found   (w_found),
        .next_id (w_next_id)
    );

    assign w_grant_oh = N_CORES'(1) << r_host_id;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state    <= ST_IDLE;
            r_last_id  <= ID_W'(N_CORES - 1);
            r_host_id  <= '0;
            r_host_irq <= 1'b0;
            r_en_clear <= '0;
            r_clear    <= '0;
            r_mask     <= '0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_tmo_cnt  <= '0;
            r_ho_cnt   <= '0;
        end else begin
            r_en_clear <= '0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_host_id  <= w_next_id;
                        r_last_id  <= w_next_id;
                        r_host_irq <= 1'b1;
                        r_tmo_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is checked first so it wins over an expiring timeout.
                    if (bus.host_ack) begin
                        r_clear    <= bus.host_clear;
                        r_mask     <= bus.host_mask;
                        r_host_irq <= 1'b0;
                        r_en_clear <= w_grant_oh;
                        r_state    <= ST_CLEAR;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_timeout  <= 1'b1;
                        r_host_irq <= 1'b0;
                        r_ho_cnt   <= '0;
                        r_state    <= ST_HOLDOFF;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_CLEAR: begin
                    r_ho_cnt <= '0;
                    r_state  <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    // Gives the cleared core time to deassert its stale request.
                    if (r_ho_cnt == HO_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ho_cnt <= r_ho_cnt + HO_W'(1);
                    end
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_host_irq <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.host_irq = r_host_irq;
    assign bus.host_id  = r_host_id;
    assign bus.en_clear = r_en_clear;
    assign bus.clear    = r_clear;
    assign bus.mask     = r_mask;
    assign bus.timeout  = r_timeout;
    assign bus.busy     = r_busy;

    a_en_clear_onehot: assert property (@(posedge clk) disable iff (!rst_a)
        $onehot0(r_en_clear));
    a_no_clear_on_timeout: assert property (@(posedge clk) disable iff (!rst_a)
        !(r_timeout && (|r_en_clear)));
    a_irq_implies_busy: assert property (@(posedge clk) disable iff (!rst_a)
        r_host_irq |-> r_busy);

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: reset, single grant, round-robin, timeout,
// ack/timeout collision, mid-operation reset and stray acks.
module tb_irq_scheduler;

    localparam int N_CORES     = 4;
    localparam int ID_W        = 2;
    localparam int STAT_WIDTH  = 16;
    localparam int TMO_CYCLES  = 1024;
    localparam int HOLDOFF_CYC = 2;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    irq_scheduler_if #(
        .N_CORES    (N_CORES),
        .ID_W       (ID_W),
        .STAT_WIDTH (STAT_WIDTH)
    ) bus ();

    irq_scheduler #(
        .N_CORES     (N_CORES),
        .ID_W        (ID_W),
        .STAT_WIDTH  (STAT_WIDTH),
        .TMO_CYCLES  (TMO_CYCLES),
        .HOLDOFF_CYC (HOLDOFF_CYC)
    ) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.int_req_n  = '1;
        bus.host_ack   = 1'b0;
        bus.host_clear = '0;
        bus.host_mask  = '0;
        rst_a = 1'b0;
        tick();
        tick();
        rst_a = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int prev;
    int w;
    int n;
    logic saw_clr;

    initial begin
        // Reset values
        bus.int_req_n  = '1;
        bus.host_ack   = 1'b0;
        bus.host_clear = '0;
        bus.host_mask  = '0;
        tick();
        check_eq("rst_irq",      32'(bus.host_irq), 0);
        check_eq("rst_id",       32'(bus.host_id),  0);
        check_eq("rst_en_clear", 32'(bus.en_clear), 0);
        check_eq("rst_clear",    32'(bus.clear),    0);
        check_eq("rst_mask",     32'(bus.mask),     0);
        check_eq("rst_timeout",  32'(bus.timeout),  0);
        check_eq("rst_busy",     32'(bus.busy),     0);
        rst_a = 1'b1;

        // Single request from core 1
        bus.int_req_n = 4'b1101;
        tick();
        check_eq("single_irq",  32'(bus.host_irq), 1);
        check_eq("single_id",   32'(bus.host_id),  1);
        check_eq("single_busy", 32'(bus.busy),     1);
        bus.int_req_n  = 4'b1111;
        bus.host_ack   = 1'b1;
        bus.host_clear = 16'h0001;
        bus.host_mask  = 16'h0001;
        tick();
        bus.host_ack = 1'b0;
        check_eq("single_en_clear", 32'(bus.en_clear), 32'b0010);
        check_eq("single_clear",    32'(bus.clear),    16'h0001);
        check_eq("single_mask",     32'(bus.mask),     16'h0001);
        check_eq("single_irq_low",  32'(bus.host_irq), 0);
        tick();
        check_eq("single_en_clear_off", 32'(bus.en_clear), 0);
        check_eq("single_holdoff_busy", 32'(bus.busy),     1);
        tick();
        check_eq("single_holdoff_busy2", 32'(bus.busy), 1);
        tick();
        check_eq("single_idle_busy", 32'(bus.busy), 0);

        // Round-robin with all cores pending, immediate ack
        do_reset();
        bus.int_req_n = 4'b0000;
        tick();
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!bus.host_irq && w < 20) begin
                tick();
                w++;
            end
            check_eq("rr_irq", 32'(bus.host_irq), 1);
            check_eq("rr_id",  32'(bus.host_id),  k % 4);
            if (k > 0) check_eq("rr_gap", cyc - prev, HOLDOFF_CYC + 3);
            prev = cyc;
            bus.host_ack = 1'b1;
            tick();
            bus.host_ack = 1'b0;
            check_eq("rr_en_clear", 32'(bus.en_clear), 1 << (k % 4));
        end

        // Timeout on core 2, then core 3 is next
        do_reset();
        bus.int_req_n = 4'b1011;
        tick();
        check_eq("tmo_id",  32'(bus.host_id),  2);
        check_eq("tmo_irq", 32'(bus.host_irq), 1);
        bus.int_req_n = 4'b0011;
        n = 0;
        saw_clr = 1'b0;
        while (bus.host_irq && n < TMO_CYCLES + 100) begin
            tick();
            n++;
            if (bus.en_clear != '0) saw_clr = 1'b1;
        end
        check_eq("tmo_cycles", n, TMO_CYCLES);
        check_eq("tmo_pulse",  32'(bus.timeout), 1);
        tick();
        check_eq("tmo_pulse_end", 32'(bus.timeout), 0);
        w = 0;
        while (!bus.host_irq && w < 20) begin
            tick();
            w++;
            if (bus.en_clear != '0) saw_clr = 1'b1;
        end
        check_eq("tmo_next_irq", 32'(bus.host_irq), 1);
        check_eq("tmo_next_id",  32'(bus.host_id),  3);
        check_eq("tmo_no_clear", 32'(saw_clr),      0);

        // Ack on the final timeout cycle
        do_reset();
        bus.int_req_n = 4'b1110;
        tick();
        check_eq("col_id", 32'(bus.host_id), 0);
        bus.int_req_n = 4'b1111;
        repeat (TMO_CYCLES - 1) tick();
        check_eq("col_irq_held", 32'(bus.host_irq), 1);
        check_eq("col_no_early", 32'(bus.timeout),  0);
        bus.host_ack   = 1'b1;
        bus.host_clear = 16'hA5A5;
        bus.host_mask  = 16'h0F0F;
        tick();
        bus.host_ack = 1'b0;
        check_eq("col_en_clear", 32'(bus.en_clear), 1);
        check_eq("col_timeout",  32'(bus.timeout),  0);
        check_eq("col_irq_low",  32'(bus.host_irq), 0);
        check_eq("col_clear",    32'(bus.clear),    16'hA5A5);
        check_eq("col_mask",     32'(bus.mask),     16'h0F0F);
        tick();
        check_eq("col_timeout_after", 32'(bus.timeout), 0);

        // Reset during WAIT_ACK
        do_reset();
        bus.int_req_n = 4'b0111;
        tick();
        check_eq("mid_id", 32'(bus.host_id), 3);
        repeat (3) tick();
        bus.int_req_n = 4'b0101;
        bus.host_ack  = 1'b1;
        rst_a = 1'b0;
        #1;
        check_eq("mid_irq",      32'(bus.host_irq), 0);
        check_eq("mid_busy",     32'(bus.busy),     0);
        check_eq("mid_id_rst",   32'(bus.host_id),  0);
        check_eq("mid_en_clear", 32'(bus.en_clear), 0);
        tick();
        check_eq("mid_en_clear_hold", 32'(bus.en_clear), 0);
        bus.host_ack = 1'b0;
        rst_a = 1'b1;
        tick();
        check_eq("mid_regrant_irq", 32'(bus.host_irq), 1);
        check_eq("mid_regrant_id",  32'(bus.host_id),  1);

        // Stray acks in IDLE and HOLDOFF
        do_reset();
        bus.host_ack = 1'b1;
        repeat (3) tick();
        check_eq("stray_idle_busy",     32'(bus.busy),     0);
        check_eq("stray_idle_irq",      32'(bus.host_irq), 0);
        check_eq("stray_idle_en_clear", 32'(bus.en_clear), 0);
        bus.host_ack  = 1'b0;
        bus.int_req_n = 4'b1110;
        tick();
        bus.int_req_n = 4'b1111;
        bus.host_ack  = 1'b1;
        tick();
        check_eq("stray_first_clear", 32'(bus.en_clear), 1);
        tick();
        check_eq("stray_ho_en_clear", 32'(bus.en_clear), 0);
        tick();
        check_eq("stray_ho_en_clear2", 32'(bus.en_clear), 0);
        check_eq("stray_ho_busy",      32'(bus.busy),     1);
        tick();
        check_eq("stray_back_idle", 32'(bus.busy),     0);
        check_eq("stray_no_irq",    32'(bus.host_irq), 0);
        bus.host_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
# irq_scheduler

Interrupt scheduler placed between several IP-core status blocks and the single host interrupt line on the NoC interface. It collects the per-core active-low interrupt requests, picks one core by round-robin, raises the host interrupt with the core index, waits for the host to finish servicing, and then issues a one-cycle clear/mask write (`en_clear`) back to the selected core's status register. A timeout stops a non-responding host from starving the other cores.

## Interface
- `N_CORES`, 4: number of IP-cores served (2..16).
- `ID_W`, 2: width of core index; must satisfy 2^ID_W >= N_CORES.
- `STAT_WIDTH`, 16: width of the clear/mask vectors delivered to each core.
- `TMO_CYCLES`, 1024: maximum WAIT_ACK duration before timeout (>= 2).
- `HOLDOFF_CYC`, 2: post-clear cycles before re-arbitration (>= 1).

- `clk` in 1: clock.
- `rst_a` in 1: reset, asynchronous, active-low.
- `int_req_n` in N_CORES: per-core request, low = interrupt pending.
- `host_ack` in 1: host has serviced the current core; `host_clear`/`host_mask` valid this cycle.
- `host_clear` in STAT_WIDTH: flags to clear in the serviced core.
- `host_mask` in STAT_WIDTH: new interrupt mask for the serviced core.
- `host_irq` out 1: interrupt to host, level.
- `host_id` out ID_W: index of the granted core, valid while `host_irq`=1.
- `en_clear` out N_CORES: one-hot, one-cycle clear strobe to the granted core.
- `clear` out STAT_WIDTH: registered copy of `host_clear`, valid with `en_clear`.
- `mask` out STAT_WIDTH: registered copy of `host_mask`, valid with `en_clear`.
- `timeout` out 1: one-cycle pulse when WAIT_ACK expires.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT_ACK, CLEAR, HOLDOFF.
- IDLE: if any `int_req_n` bit is 0, grant the first pending core searching upward from `last_id+1` (wrapping at N_CORES-1 to 0). Register `host_id` and `last_id`, set `host_irq`=1, and go to WAIT_ACK.
- WAIT_ACK:
  - A 1 on `host_ack` captures `host_clear`/`host_mask` into `clear`/`mask`, drops `host_irq`, and goes to CLEAR.
  - Otherwise the timeout counter increments. When it reaches TMO_CYCLES-1 with no ack, pulse `timeout`, drop `host_irq`, and go to HOLDOFF without a clear.
- CLEAR: `en_clear[host_id]`=1 for exactly this cycle, then go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYC cycles, then go to IDLE. This masks the stale request from the just-cleared core.
- `host_ack` is ignored outside WAIT_ACK.
- A request withdrawn (`int_req_n` back to 1) during WAIT_ACK does not cancel the grant.
- The timeout counter clears on every WAIT_ACK entry.
- `last_id` updates even on timeout, so the next arbitration starts after the timed-out core.
- Reset values:
  - `host_irq`, `en_clear`, `timeout`, `busy`: 0. `host_id`, `clear`, `mask`: 0.
  - State IDLE; `last_id`=N_CORES-1, so core 0 has first priority.
  - Reset asserted mid-operation aborts immediately, and no `en_clear` is emitted.

## Timing
- `int_req_n` low sampled at edge k in IDLE: `host_irq`/`host_id` valid after edge k+1.
- `host_ack` sampled at edge a: `host_irq` low after a+1. `en_clear` high between a+1 and a+2.
- After `en_clear`, the earliest new `host_irq` is HOLDOFF_CYC+2 cycles later.
- Timeout: `timeout` and `host_irq` low appear TMO_CYCLES cycles after `host_irq` rises.
- Simultaneous `host_ack` and the last timeout cycle: ack wins, and no `timeout` pulse is emitted.
- All outputs are registered.

## Structure
- Package `irq_sched_pkg` holds the state enum (2-bit encoding) and a function for ID_W sizing.
- Sub-module `rr_arbiter` (N_CORES, ID_W): inputs are the pending vector and `last_id`; outputs are `found` and `next_id`. It is combinational, and its output is registered by the FSM.
- Counters: a timeout counter of $clog2(TMO_CYCLES) bits and a holdoff counter of $clog2(HOLDOFF_CYC+1) bits.

## Test plan
- Single request: after reset, drive `int_req_n`=4'b1101. Expect `host_irq`=1 and `host_id`=1 one cycle later. Ack with `host_clear`=16'h0001, `host_mask`=16'h0001. Expect `en_clear`=4'b0010 for one cycle with `clear`=16'h0001.
- Round-robin: hold all four requests low continuously and ack immediately. Expect grant order 0,1,2,3,0, with spacing of HOLDOFF_CYC+3 cycles.
- Timeout: request core 2 and never ack. Expect a `timeout` pulse after 1024 cycles, no `en_clear`, then the next grant to core 3 if it is pending, else core 2 again.
- Ack/timeout collision: ack on the final timeout cycle. Expect `en_clear` to be emitted and `timeout` to stay 0.
- Reset mid-operation: assert `rst_a`=0 in WAIT_ACK, then release. Expect all outputs 0 and no `en_clear`. The first grant afterwards goes to the lowest pending core.
- Stray ack: pulse `host_ack` in IDLE and in HOLDOFF. Expect no state change and no `en_clear`.
